// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the multi-character UART transmitter
package uart_pkg;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int frame_len(input int data_bits, input int stop_bits, input int parity_bits);
    return 1 + data_bits + parity_bits + stop_bits;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_multichar.sv
// rtl/uart_tx_multichar.sv - serialises NBYTES characters per request on TxD, timed by tx_en
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_multichar
  import uart_pkg::*;
#(
  parameter int NBYTES     = 2,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_en,
  input  logic                        tx_start,
  input  logic [NBYTES*DATA_BITS-1:0] tx_data,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        TxD
);

  localparam int WORD_W = NBYTES * DATA_BITS;
  localparam int BIT_W  = cnt_width(DATA_BITS + 1);
  localparam int BYTE_W = cnt_width(NBYTES);

  generate
    if (NBYTES < 1 || NBYTES > 16 || DATA_BITS < 5 || DATA_BITS > 8 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_err
      $error("uart_tx_multichar: parameter out of range");
    end
  endgenerate

  tx_state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0]    r_word, w_word_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_nxt;
  logic [BYTE_W-1:0]    r_byte_cnt, w_byte_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_txd, w_txd_nxt;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
  logic                 r_par, w_par_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_txd      <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_byte_cnt <= w_byte_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_txd      <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  // r_shift holds the character on the line; r_word holds the characters still to come.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_byte_nxt  = r_byte_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_txd_nxt   = IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_state_nxt = SYNC;
          w_shift_nxt = tx_data[DATA_BITS-1:0];
          w_word_nxt  = tx_data >> DATA_BITS;
          w_bit_nxt   = '0;
          w_byte_nxt  = '0;
          w_busy_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = (^tx_data[DATA_BITS-1:0]) ^ PAR_SENSE;
`endif
        end
      end
      SYNC: begin
        if (tx_en) w_state_nxt = START;
      end
      START: begin
        if (tx_en) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (tx_en) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tx_en) begin
          w_state_nxt = STOP;
          w_bit_nxt   = '0;
        end
      end
`endif
      STOP: begin
        if (tx_en) begin
          if (r_bit_cnt != BIT_W'(STOP_BITS - 1)) begin
            w_bit_nxt = r_bit_cnt + BIT_W'(1);
          end else if (r_byte_cnt == BYTE_W'(NBYTES - 1)) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = START;
            w_byte_nxt  = r_byte_cnt + BYTE_W'(1);
            w_shift_nxt = r_word[DATA_BITS-1:0];
            w_word_nxt  = r_word >> DATA_BITS;
`ifdef UART_TX_PARITY_EN
            w_par_nxt   = (^r_word[DATA_BITS-1:0]) ^ PAR_SENSE;
`endif
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level is decoded from the next state so TxD changes on the same edge as the state.
    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_txd_nxt = w_par_nxt;
`endif
      default: w_txd_nxt = IDLE_LEVEL;
    endcase
  end

  assign tx_busy = r_busy;
  assign tx_done = r_done;
  assign TxD     = r_txd;

endmodule

// File: tb/tb_uart_tx_multichar.sv
// tb/tb_uart_tx_multichar.sv - self-checking bench for uart_tx_multichar
module tb_uart_tx_multichar;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic        a_start = 1'b0, a_busy, a_done, a_txd;
  logic [15:0] a_data = '0;
  logic        b_start = 1'b0, b_busy, b_done, b_txd;
  logic [6:0]  b_data = '0;
`ifdef UART_TX_PARITY_EN
  logic        c_start = 1'b0, c_busy, c_done, c_txd;
  logic [7:0]  c_data = '0;
  logic        c_bseen = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;
  logic tick_seen = 1'b0, a_bseen = 1'b0, b_bseen = 1'b0;
  logic a_done_prev = 1'b0;
  int   a_done_cnt = 0;
  int   gap_run = 0;
  bit   gap_log = 1'b0;
  int   gaps[$];
  bit   cap_q[$];
  bit   exp_q[$];

  typedef struct {
    logic [15:0] data;
    logic [31:0] bits;
    int          len;
  } vec_t;
  vec_t tv[3];

  uart_tx_multichar dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_start(a_start), .tx_data(a_data),
    .tx_busy(a_busy), .tx_done(a_done), .TxD(a_txd)
  );

  uart_tx_multichar #(.NBYTES(1), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_start(b_start), .tx_data(b_data),
    .tx_busy(b_busy), .tx_done(b_done), .TxD(b_txd)
  );

`ifdef UART_TX_PARITY_EN
  uart_tx_multichar #(.NBYTES(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_c (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_start(c_start), .tx_data(c_data),
    .tx_busy(c_busy), .tx_done(c_done), .TxD(c_txd)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      en_cnt = (en_cnt + 1) % 4;
      tx_en  = (en_cnt == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Values seen by the DUT on the most recent rising edge.
  always @(posedge clk) begin
    tick_seen <= tx_en;
    a_bseen   <= a_busy;
    b_bseen   <= b_busy;
`ifdef UART_TX_PARITY_EN
    c_bseen   <= c_busy;
`endif
  end

  // A bit period starts on every tick edge that keeps the transmitter busy.
  always @(negedge clk) begin
    if (tick_seen && a_bseen && a_busy) cap_q.push_back(a_txd);
    if (a_done) begin
      a_done_cnt++;
      check_int("done_with_busy_fall", int'({a_bseen, a_busy}), 2);
      check_int("done_width", int'(a_done_prev), 0);
    end
    a_done_prev = a_done;
    if (!a_busy) gap_run++;
    else begin
      if (gap_log && gap_run > 0) gaps.push_back(gap_run);
      gap_run = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference frame: start, data LSB first, optional parity, stop.
  task automatic model_push(input logic [15:0] d);
    for (int c = 0; c < 2; c++) begin
      int ch;
      ch = (int'(d) >> (8 * c)) & 8'hFF;
      exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_q.push_back(bit'((ch >> b) & 1));
`ifdef UART_TX_PARITY_EN
      exp_q.push_back(bit'($countones(ch) % 2));
`endif
      exp_q.push_back(1'b1);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && a_busy; i++) step();
    check_int("idle_timeout", int'(a_busy), 0);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && a_done_cnt < target; i++) step();
    check_int("done_count", a_done_cnt, target);
  endtask

  task automatic send_a(input logic [15:0] d);
    wait_idle();
    a_data  = d;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
  endtask

  task automatic check_stream(input string name);
    logic [127:0] av, ev;
    av = '0;
    ev = '0;
    for (int i = 0; i < cap_q.size() && i < 128; i++) av[i] = cap_q[i];
    for (int i = 0; i < exp_q.size() && i < 128; i++) ev[i] = exp_q[i];
    check_int({name, "_len"}, cap_q.size(), exp_q.size());
    check_vec(name, av, ev);
    cap_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [3:0] sig(input int k);
    logic [3:0] s;
    s = {b_busy, b_bseen, b_txd, b_done};
`ifdef UART_TX_PARITY_EN
    if (k == 1) s = {c_busy, c_bseen, c_txd, c_done};
`endif
    return s;
  endfunction

  task automatic run_single(input int k, input logic [7:0] d, input logic [31:0] ev,
                            input int elen, input string nm);
    logic [31:0] av;
    logic [3:0]  s;
    int n, dc;
    av = '0;
    n  = 0;
    dc = 0;
    if (k == 0) begin
      b_data  = d[6:0];
      b_start = 1'b1;
    end
`ifdef UART_TX_PARITY_EN
    else begin
      c_data  = d;
      c_start = 1'b1;
    end
`endif
    step();
    b_start = 1'b0;
`ifdef UART_TX_PARITY_EN
    c_start = 1'b0;
`endif
    for (int i = 0; i < 400; i++) begin
      step();
      s = sig(k);
      if (s[0]) dc++;
      if (tick_seen && s[2] && s[3]) begin
        if (n < 32) av[n] = s[1];
        n++;
      end
      if (!s[3]) break;
    end
    check_int({nm, "_len"}, n, elen);
    check_vec(nm, 128'(av), 128'(ev));
    check_int({nm, "_done"}, dc, 1);
  endtask

  initial begin
    int base;
    logic [15:0] d;
    logic [127:0] av;

`ifdef UART_TX_PARITY_EN
    tv[0] = '{16'hBC0A, 32'({1'b1, 1'b1, 8'hBC, 1'b0, 1'b1, 1'b0, 8'h0A, 1'b0}), 22};
    tv[1] = '{16'h00FF, 32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0}), 22};
    tv[2] = '{16'h0701, 32'({1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0}), 22};
`else
    tv[0] = '{16'hBC0A, 32'({1'b1, 8'hBC, 1'b0, 1'b1, 8'h0A, 1'b0}), 20};
    tv[1] = '{16'h00FF, 32'({1'b1, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0}), 20};
    tv[2] = '{16'h0701, 32'({1'b1, 8'h07, 1'b0, 1'b1, 8'h01, 1'b0}), 20};
`endif

    rst = 1'b1;
    repeat (3) step();
    check_int("rst_txd", int'(a_txd), 1);
    check_int("rst_busy", int'(a_busy), 0);
    check_int("rst_done", int'(a_done), 0);
    check_int("rst_b_txd", int'(b_txd), 1);
    rst = 1'b0;
    repeat (5) step();
    check_int("idle_txd", int'(a_txd), 1);
    check_int("idle_busy", int'(a_busy), 0);

    for (int i = 0; i < 3; i++) begin
      base = a_done_cnt;
      cap_q.delete();
      send_a(tv[i].data);
      wait_done(base + 1);
      av = '0;
      for (int j = 0; j < cap_q.size() && j < 128; j++) av[j] = cap_q[j];
      check_int("table_len", cap_q.size(), tv[i].len);
      check_vec("table_bits", av, 128'(tv[i].bits));
      cap_q.delete();
    end

    for (int i = 0; i < 8; i++) begin
      base = a_done_cnt;
      d = 16'($urandom);
      send_a(d);
      model_push(d);
      repeat ($urandom_range(3, 50)) step();
      a_start = 1'b1;
      a_data  = 16'($urandom);
      step();
      a_start = 1'b0;
      wait_done(base + 1);
      repeat (3) step();
      check_int("ignored_start", int'(a_busy), 0);
      check_stream("rand_word");
    end

    wait_idle();
    base = a_done_cnt;
    cap_q.delete();
    exp_q.delete();
    a_data  = 16'hC35A;
    a_start = 1'b1;
    repeat (3) model_push(16'hC35A);
    step();
    gaps.delete();
    gap_run = 0;
    gap_log = 1'b1;
    for (int i = 0; i < 6000 && a_done_cnt < base + 3; i++) step();
    a_start = 1'b0;
    gap_log = 1'b0;
    check_int("held_done_count", a_done_cnt, base + 3);
    repeat (10) step();
    check_int("held_no_fourth", int'(a_busy), 0);
    check_stream("held_words");
    check_int("held_gap_count", gaps.size(), 2);
    foreach (gaps[i]) check_int("held_gap_len", gaps[i], 1);

    cap_q.delete();
    exp_q.delete();
    send_a(16'h55F0);
    for (int i = 0; i < 2000 && cap_q.size() < 5; i++) step();
    check_int("pre_rst_txd", int'(a_txd), 0);
    check_int("pre_rst_busy", int'(a_busy), 1);
    rst = 1'b1;
    #1;
    check_int("async_rst_txd", int'(a_txd), 1);
    check_int("async_rst_busy", int'(a_busy), 0);
    check_int("async_rst_done", int'(a_done), 0);
    step();
    step();
    rst = 1'b0;
    step();
    cap_q.delete();
    exp_q.delete();
    base = a_done_cnt;
    send_a(16'h3C96);
    model_push(16'h3C96);
    wait_done(base + 1);
    check_stream("after_rst");

`ifdef UART_TX_PARITY_EN
    run_single(0, 8'h41, 32'({2'b11, 1'b0, 7'h41, 1'b0}), 11, "b_7n2");
    run_single(1, 8'h0A, 32'({1'b1, 1'b1, 8'h0A, 1'b0}), 11, "c_odd_par");
`else
    run_single(0, 8'h41, 32'({2'b11, 7'h41, 1'b0}), 10, "b_7n2");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_multichar.md
Name: uart_tx_multichar

Overview:
- Parametrised successor of the fixed 8N1 multi-byte UART transmitter.
- Serialises one word of NBYTES characters per request over a single TxD line.
- Configurable character width and stop-bit count; word-complete strobe.
- Bit timing comes from an external one-clock baud tick (tx_en), generated by BaudGen from the PLL clock.

Parameters:
- NBYTES, 2, characters per word (1..16).
- DATA_BITS, 8, bits per character (5..8).
- STOP_BITS, 1, stop bits per character (1 or 2).
- PARITY_ODD, 0, parity sense when the optional parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  in  1  system clock (PLL output).
- rst  in  1  asynchronous, active-high reset.
- tx_en  in  1  baud tick, one clk wide, one per bit period.
- tx_start  in  1  level request; sampled on clk.
- tx_data  in  NBYTES*DATA_BITS  word; character 0 = tx_data[DATA_BITS-1:0], sent first.
- tx_busy  out  1  high from word latch until return to IDLE.
- tx_done  out  1  one-clk pulse when the last stop bit of the last character completes.
- TxD  out  1  serial output, idle high.

Behaviour:
- Reset (async, immediate, also mid-word):
  - TxD=1, tx_busy=0, tx_done=0, state=IDLE.
  - Counters and shift register cleared.
  - Any partial frame is abandoned.
- Outputs are registered; no combinational path from any input to any output.
- States and transitions:
  - IDLE: tx_start=1 → latch tx_data into the word register, byte_cnt=0, go to SYNC. tx_busy rises on the same edge.
  - SYNC: TxD=1; wait for tx_en → START. Aligns the first bit to a full baud period.
  - START: TxD=0; on tx_en → DATA, bit_cnt=0.
  - DATA: TxD = current character bit, LSB first; on tx_en advance bit_cnt. After DATA_BITS ticks → PARITY if compiled in, else STOP.
  - PARITY (optional): TxD = parity bit; on tx_en → STOP.
  - STOP: TxD=1 for STOP_BITS ticks. Then:
    - if byte_cnt < NBYTES-1: increment byte_cnt, shift the next character in, → START. No extra idle between characters.
    - else → IDLE and pulse tx_done.
- tx_en in IDLE is ignored.
- tx_start while busy is ignored; tx_data is not re-sampled while busy.
- tx_start held high: the next word latches on the clk after the return to IDLE. tx_busy drops for exactly one clk.
- tx_done and the tx_busy fall occur on the same edge.
- Frame length per character = 1 + DATA_BITS + P + STOP_BITS, where P = 1 with parity, 0 without.
- Counter widths: bit_cnt = $clog2(DATA_BITS+1); byte_cnt = $clog2(NBYTES), minimum 1 bit.
- Elaboration error if any parameter is outside its stated range.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is present.
  - Parity bit = ^character XOR PARITY_ODD, computed on the latched character.
  - Frame is 1+DATA_BITS+1+STOP_BITS ticks.
- Undefined:
  - PARITY state and its logic are absent.
  - PARITY_ODD is ignored.
  - Frame is 1+DATA_BITS+STOP_BITS ticks.

Decomposition:
- Package uart_pkg holds:
  - the tx state typedef (IDLE, SYNC, START, DATA, PARITY, STOP);
  - localparam helpers: frame-length function and counter-width function;
  - IDLE_LEVEL = 1'b1.
- No sub-module. The sequencer, counters and shift register stay in one module; baud generation stays external in BaudGen.

Test Plan:
- Bench setup: tx_en every 4 clk; defaults, parity off.
- Single word: tx_data=16'hBC0A, tx_start pulsed high for 1 clk.
  - TxD sequence: 0, 0,1,0,1,0,0,0,0, 1, then 0, 0,0,1,1,1,1,0,1, 1.
  - tx_busy high for 20 ticks plus SYNC; tx_done one pulse.
- tx_start held high for 3 words: three back-to-back words, three tx_done pulses, tx_busy low for exactly 1 clk between words.
- Reset mid-character: assert rst during DATA bit 3.
  - TxD=1 and tx_busy=0 in the same clk, without waiting for an edge.
  - After release, a fresh tx_start sends a complete word from START.
- NBYTES=1, DATA_BITS=7, STOP_BITS=2, tx_data=7'h41: 10 ticks per frame; TxD = 0, 1,0,0,0,0,0,1, 1,1.
- UART_TX_PARITY_EN, PARITY_ODD=0, character 8'h0A: parity bit 0. With PARITY_ODD=1: parity bit 1. Frame is 11 ticks.
- tx_start pulsed and tx_data changed while busy: no effect on TxD. tx_done count equals the number of accepted requests.
